// File: rtl/imm_decode_stage.sv
// Registered RV32I immediate-decode stage.
// Classifies an instruction word into an immediate format and assembles the
// extended 32-bit immediate. IMM and IMM_TYPE appear one cycle after an
// instruction is accepted with VALID_IN=1, and hold while VALID_IN=0.
module imm_decode_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR,
    input  logic        VALID_IN,
    output logic [31:0] IMM,
    output logic [2:0]  IMM_TYPE,
    output logic        VALID_OUT
);

    // Immediate format codes as presented on IMM_TYPE.
    typedef enum logic [2:0] {
        IMM_NONE = 3'b000,
        IMM_I    = 3'b001,
        IMM_S    = 3'b010,
        IMM_B    = 3'b011,
        IMM_U    = 3'b100,
        IMM_J    = 3'b101,
        IMM_CSR  = 3'b110
    } imm_type_e;

    // Major opcodes, INSTR[6:2]; INSTR[1:0] is not part of the decode.
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic        sgn;

    imm_type_e   imm_type_d;
    imm_type_e   imm_type_q;
    logic [31:0] imm_d;
    logic [31:0] imm_q;
    logic        valid_q;

    assign opcode = INSTR[6:2];
    assign funct3 = INSTR[14:12];
    assign sgn    = INSTR[31];

    // Classify the instruction into an immediate format.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        imm_type_d = IMM_NONE;
        unique case (opcode)
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR:   imm_type_d = IMM_I;
            OPC_STORE:  imm_type_d = IMM_S;
            OPC_BRANCH: imm_type_d = IMM_B;
            OPC_LUI,
            OPC_AUIPC:  imm_type_d = IMM_U;
            OPC_JAL:    imm_type_d = IMM_J;
            // funct3=000 is ECALL/EBREAK/xRET, which carry no immediate.
            OPC_SYSTEM: imm_type_d = (funct3 != 3'b000) ? IMM_CSR : IMM_NONE;
            default:    imm_type_d = IMM_NONE;
        endcase
    end

    // Assemble the extended immediate for the selected format.
    always_comb begin
        imm_d = 32'h0000_0000;
        unique case (imm_type_d)
            // Shift-immediates take the plain I-format value; no shamt masking.
            IMM_I:   imm_d = {{20{sgn}}, INSTR[31:20]};
            IMM_S:   imm_d = {{20{sgn}}, INSTR[31:25], INSTR[11:7]};
            IMM_B:   imm_d = {{19{sgn}}, sgn, INSTR[7], INSTR[30:25],
                              INSTR[11:8], 1'b0};
            IMM_U:   imm_d = {INSTR[31:12], 12'h000};
            IMM_J:   imm_d = {{11{sgn}}, sgn, INSTR[19:12], INSTR[20],
                              INSTR[30:21], 1'b0};
            // CSR*I forms use the rs1 field as a zero-extended 5-bit uimm.
            IMM_CSR: imm_d = {27'b0, INSTR[19:15]};
            default: imm_d = 32'h0000_0000;
        endcase
    end

    // Output register: load on accepted instructions, otherwise hold.
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RESET) begin
            imm_q      <= 32'h0000_0000;
            imm_type_q <= IMM_NONE;
        end else if (VALID_IN) begin
            imm_q      <= imm_d;
            imm_type_q <= imm_type_d;
        end
    end

    // Valid flag follows VALID_IN on every edge, accepted or not.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= VALID_IN;
        end
    end

    assign IMM       = imm_q;
    assign IMM_TYPE  = imm_type_q;
    assign VALID_OUT = valid_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage. Expected results are queued when
// stimulus is driven and compared one cycle later when the DUT presents them.
module tb_imm_decode_stage;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTR;
    logic        VALID_IN;
    logic [31:0] IMM;
    logic [2:0]  IMM_TYPE;
    logic        VALID_OUT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        vld;
    } exp_t;

    exp_t sb[$];

    imm_decode_stage dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .INSTR     (INSTR),
        .VALID_IN  (VALID_IN),
        .IMM       (IMM),
        .IMM_TYPE  (IMM_TYPE),
        .VALID_OUT (VALID_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference decoder built from signed field widths and sign-extending casts.
    function automatic void ref_decode(input logic [31:0] ins,
                                       output logic [31:0] imm,
                                       output logic [2:0] typ);
        logic signed [11:0] f12;
        logic signed [12:0] f13;
        logic signed [20:0] f21;
        imm = '0;
        typ = 3'd0;
        case (ins[6:2])
            5'b00100, 5'b00000, 5'b11001: begin
                f12 = ins[31:20];
                imm = 32'(f12);
                typ = 3'd1;
            end
            5'b01000: begin
                f12 = {ins[31:25], ins[11:7]};
                imm = 32'(f12);
                typ = 3'd2;
            end
            5'b11000: begin
                f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                imm = 32'(f13);
                typ = 3'd3;
            end
            5'b01101, 5'b00101: begin
                imm = ins & 32'hFFFF_F000;
                typ = 3'd4;
            end
            5'b11011: begin
                f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                imm = 32'(f21);
                typ = 3'd5;
            end
            5'b11100: begin
                if (ins[14:12] != 3'b000) begin
                    imm = 32'(ins[19:15]);
                    typ = 3'd6;
                end
            end
            default: ;
        endcase
    endfunction

    // Drive one instruction for one edge, queue its expectation, then settle.
    task automatic drive(input logic [31:0] ins, input logic v,
                         input logic [31:0] e_imm, input logic [2:0] e_typ);
        @(negedge CLK);
        INSTR    = ins;
        VALID_IN = v;
        sb.push_back('{imm: e_imm, typ: e_typ, vld: v});
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        RESET    = 1'b1;
        INSTR    = 32'h0;
        VALID_IN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        // Put non-zero state in the register so the async clear is visible.
        drive(32'h1234_5037, 1'b1, 32'h1234_5000, 3'd4);
        e = sb.pop_front();
        checks++;
        if (IMM !== e.imm || IMM_TYPE !== e.typ || VALID_OUT !== e.vld) begin
            errors++;
            $display("FAIL reset_preload: got imm=%h type=%0d vld=%b expected imm=%h type=%0d vld=%b",
                     IMM, IMM_TYPE, VALID_OUT, e.imm, e.typ, e.vld);
        end
        // Assert reset away from any clock edge with a valid instruction present.
        @(negedge CLK);
        #2;
        INSTR    = 32'hFFFF_F013;
        VALID_IN = 1'b1;
        RESET    = 1'b1;
        #1;
        checks++;
        if (IMM !== 32'h0 || IMM_TYPE !== 3'd0 || VALID_OUT !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got imm=%h type=%0d vld=%b expected imm=00000000 type=0 vld=0",
                     IMM, IMM_TYPE, VALID_OUT);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (IMM !== 32'h0 || IMM_TYPE !== 3'd0 || VALID_OUT !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got imm=%h type=%0d vld=%b expected imm=00000000 type=0 vld=0",
                     IMM, IMM_TYPE, VALID_OUT);
        end
        RESET = 1'b0;
        sb.delete();
        drive(32'hFFFF_F013, 1'b1, 32'hFFFF_FFFF, 3'd1);
        e = sb.pop_front();
        checks++;
        if (IMM !== e.imm || IMM_TYPE !== e.typ || VALID_OUT !== e.vld) begin
            errors++;
            $display("FAIL reset_release: got imm=%h type=%0d vld=%b expected imm=%h type=%0d vld=%b",
                     IMM, IMM_TYPE, VALID_OUT, e.imm, e.typ, e.vld);
        end
    endtask

    task automatic test_formats();
        logic [31:0] ins_tab [7] = '{32'hFE00_0FA3, 32'h8000_0063, 32'h8000_006F,
                                     32'h1234_5037, 32'h000F_D073, 32'h0000_0073,
                                     32'h0020_80B3};
        logic [31:0] imm_tab [7] = '{32'hFFFF_FFFF, 32'hFFFF_F000, 32'hFFF0_0000,
                                     32'h1234_5000, 32'h0000_001F, 32'h0000_0000,
                                     32'h0000_0000};
        logic [2:0]  typ_tab [7] = '{3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd0, 3'd0};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            drive(ins_tab[i], 1'b1, imm_tab[i], typ_tab[i]);
            e = sb.pop_front();
            checks++;
            if (IMM !== e.imm || IMM_TYPE !== e.typ || VALID_OUT !== e.vld) begin
                errors++;
                $display("FAIL format_%0d (%h): got imm=%h type=%0d vld=%b expected imm=%h type=%0d vld=%b",
                         i, ins_tab[i], IMM, IMM_TYPE, VALID_OUT, e.imm, e.typ, e.vld);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        drive(32'h7FF0_0093, 1'b1, 32'h0000_07FF, 3'd1);
        drive(32'h1234_5037, 1'b0, 32'h0000_07FF, 3'd1);
        drive(32'h8000_006F, 1'b0, 32'h0000_07FF, 3'd1);
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            // Comparisons lag the pushes here; each entry is still checked in order.
            checks++;
            if (e.vld == 1'b0 && i < 2 && VALID_OUT !== 1'b0) begin
                errors++;
                $display("FAIL hold_valid_%0d: got vld=%b expected vld=0", i, VALID_OUT);
            end
            if (IMM !== e.imm || IMM_TYPE !== e.typ) begin
                errors++;
                $display("FAIL hold_%0d: got imm=%h type=%0d expected imm=%h type=%0d",
                         i, IMM, IMM_TYPE, e.imm, e.typ);
            end
        end
        // Next accepted instruction loads again after the hold.
        drive(32'h8000_0063, 1'b1, 32'hFFFF_F000, 3'd3);
        e = sb.pop_front();
        checks++;
        if (IMM !== e.imm || IMM_TYPE !== e.typ || VALID_OUT !== e.vld) begin
            errors++;
            $display("FAIL hold_resume: got imm=%h type=%0d vld=%b expected imm=%h type=%0d vld=%b",
                     IMM, IMM_TYPE, VALID_OUT, e.imm, e.typ, e.vld);
        end
    endtask

    task automatic test_random_sweep();
        logic [4:0]  opc_tab [10] = '{5'b00100, 5'b00000, 5'b11001, 5'b01000, 5'b11000,
                                      5'b01101, 5'b00101, 5'b11011, 5'b11100, 5'b01100};
        logic [31:0] ins;
        logic [31:0] e_imm;
        logic [2:0]  e_typ;
        exp_t        e;
        int          sweep_err;
        for (int o = 0; o < 10; o++) begin
            sweep_err = 0;
            for (int n = 0; n < 600; n++) begin
                ins = {$urandom_range(32'h01FF_FFFF, 0)} << 7;
                ins = ins | {25'b0, opc_tab[o], 2'($urandom_range(3, 0))};
                ref_decode(ins, e_imm, e_typ);
                drive(ins, 1'b1, e_imm, e_typ);
                e = sb.pop_front();
                checks++;
                if (IMM !== e.imm || IMM_TYPE !== e.typ || VALID_OUT !== e.vld) begin
                    errors++;
                    sweep_err++;
                    if (sweep_err <= 5)
                        $display("FAIL sweep_opc_%b (%h): got imm=%h type=%0d vld=%b expected imm=%h type=%0d vld=%b",
                                 opc_tab[o], ins, IMM, IMM_TYPE, VALID_OUT, e.imm, e.typ, e.vld);
                end
            end
        end
    endtask

    initial begin
        RESET    = 1'b1;
        INSTR    = 32'h0;
        VALID_IN = 1'b0;
        test_reset();
        test_formats();
        test_hold();
        test_random_sweep();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
